// File: rtl/avalon_arb_pkg.sv
// avalon_arb_pkg: shared state encoding and default widths for the burst arbiter.
package avalon_arb_pkg;
  typedef enum logic [1:0] {IDLE, RD_CMD, RD_DATA, WR_BURST} arb_state_t;
  localparam int AW_DEF  = 32;
  localparam int DW_DEF  = 32;
  localparam int BCW_DEF = 5;
endpackage

// File: rtl/burst_beat_counter.sv
// burst_beat_counter: latches a burst length on the first load, counts beats and flags the last one.
module burst_beat_counter import avalon_arb_pkg::*; #(
  parameter int BCW = BCW_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load_i,
  input  logic [BCW-1:0] bc_i,
  input  logic           inc_i,
  output logic           last_o,
  output logic           zero_o
);
  logic [BCW-1:0] total_q, total_d, cnt_q, cnt_d;
  logic           start;
  always_comb begin
    start   = load_i && cnt_q == '0;
    total_d = start ? (bc_i == '0 ? BCW'(1) : bc_i) : total_q;
    zero_o  = start && bc_i == '0;
    last_o  = inc_i && (cnt_q + BCW'(1) == total_d);
    cnt_d   = last_o ? '0 : inc_i ? cnt_q + BCW'(1) : start ? '0 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      total_q <= '0;
      cnt_q   <= '0;
    end else begin
      total_q <= total_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: rtl/avalon_burst_arbiter.sv
// avalon_burst_arbiter: burst-granular VGA-read / stream-write arbiter in front of one SDRAM agent,
// VGA has priority unless the stream has waited STARVE_MAX cycles.
module avalon_burst_arbiter import avalon_arb_pkg::*; #(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int BCW        = BCW_DEF,
  parameter int STARVE_MAX = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   vga_address,
  input  logic [BCW-1:0]  vga_burstcount,
  input  logic            vga_read,
  output logic [DW-1:0]   vga_readdata,
  output logic            vga_readdatavalid,
  output logic            vga_waitrequest,
  input  logic [AW-1:0]   st_address,
  input  logic [DW/8-1:0] st_byteenable,
  input  logic [BCW-1:0]  st_burstcount,
  input  logic            st_write,
  input  logic [DW-1:0]   st_writedata,
  output logic            st_waitrequest,
  output logic [AW-1:0]   sd_address,
  output logic [DW/8-1:0] sd_byteenable,
  output logic [BCW-1:0]  sd_burstcount,
  output logic            sd_read,
  output logic            sd_write,
  output logic [DW-1:0]   sd_writedata,
  input  logic [DW-1:0]   sd_readdata,
  input  logic            sd_readdatavalid,
  input  logic            sd_waitrequest,
  output logic            grant_vga,
  output logic            grant_st,
  output logic            proto_err
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  arb_state_t    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          proto_err_q, proto_err_d;
  logic          rd_acc, rd_beat, rd_last, rd_zero, wr_acc, wr_last, wr_zero;
  assign grant_vga         = state_q == RD_CMD || state_q == RD_DATA;
  assign grant_st          = state_q == WR_BURST;
  assign sd_read           = state_q == RD_CMD && vga_read;
  assign sd_write          = grant_st && st_write;
  assign sd_address        = grant_st ? st_address : vga_address;
  assign sd_byteenable     = grant_st ? st_byteenable : '1;
  assign sd_burstcount     = grant_st ? st_burstcount : vga_burstcount;
  assign sd_writedata      = grant_st ? st_writedata : '0;
  assign vga_waitrequest   = state_q == RD_CMD ? sd_waitrequest : 1'b1;
  assign st_waitrequest    = grant_st ? sd_waitrequest : 1'b1;
  assign vga_readdatavalid = state_q == RD_DATA && sd_readdatavalid;
  assign vga_readdata      = state_q == RD_DATA ? sd_readdata : '0;
  assign proto_err         = proto_err_q;
  assign rd_acc            = sd_read && !sd_waitrequest;
  assign rd_beat           = vga_readdatavalid;
  assign wr_acc            = sd_write && !sd_waitrequest;
  burst_beat_counter #(.BCW(BCW)) u_rd_cnt (
    .clk, .reset, .load_i(rd_acc), .bc_i(vga_burstcount), .inc_i(rd_beat),
    .last_o(rd_last), .zero_o(rd_zero)
  );
  burst_beat_counter #(.BCW(BCW)) u_wr_cnt (
    .clk, .reset, .load_i(wr_acc), .bc_i(st_burstcount), .inc_i(wr_acc),
    .last_o(wr_last), .zero_o(wr_zero)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = (vga_read && !(st_write && starve_q == SW'(STARVE_MAX))) ? RD_CMD :
                          st_write ? WR_BURST : IDLE;
      RD_CMD:   state_d = rd_acc ? RD_DATA : RD_CMD;
      RD_DATA:  state_d = rd_last ? IDLE : RD_DATA;
      WR_BURST: state_d = wr_last ? IDLE : WR_BURST;
      default:  state_d = IDLE;
    endcase
    starve_d    = (state_q != WR_BURST && state_d == WR_BURST) ? '0 :
                  (st_write && state_q != WR_BURST && starve_q != SW'(STARVE_MAX)) ? starve_q + SW'(1) :
                  starve_q;
    // read beats with no read burst in flight are orphans and are discarded
    proto_err_d = proto_err_q || rd_zero || wr_zero || (sd_readdatavalid && state_q != RD_DATA);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      proto_err_q <= proto_err_d;
    end
  end
endmodule

// File: doc/avalon_burst_arbiter.md
Name: avalon_burst_arbiter

Overview:
- Registered, burst-aware two-host arbiter sharing one Avalon-MM SDRAM agent between the VGA read host (display refill, high priority) and the stream write host (frame capture).
- Grants whole bursts: one burst is outstanding at a time, and ownership changes only at burst boundaries.
- An anti-starvation counter guarantees stream progress under continuous VGA demand.
- Sits between the VGA/stream hosts and the SDRAM controller port.

Parameters:
- AW, 32, address width (bytes).
- DW, 32, data width; byteenable width is DW/8.
- BCW, 5, burstcount width (max legal burst 16).
- STARVE_MAX, 64, cycles a pending stream write may wait before it beats VGA at the next arbitration point.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- vga_address / vga_burstcount / vga_read  in  AW / BCW / 1  VGA host command.
- vga_readdata  out  DW  read data; 0 when not owner.
- vga_readdatavalid  out  1  read beat valid.
- vga_waitrequest  out  1  command stall.
- st_address / st_byteenable / st_burstcount / st_write / st_writedata  in  AW / DW/8 / BCW / 1 / DW  stream host command.
- st_waitrequest  out  1  command/beat stall.
- sd_address / sd_byteenable / sd_burstcount / sd_read / sd_write / sd_writedata  out  AW / DW/8 / BCW / 1 / 1 / DW  SDRAM command.
- sd_readdata / sd_readdatavalid / sd_waitrequest  in  DW / 1 / 1  SDRAM response.
- grant_vga  out  1  VGA owns the port.
- grant_st  out  1  stream owns the port.
- proto_err  out  1  sticky protocol-error flag.

Behaviour:
- States: IDLE, RD_CMD, RD_DATA, WR_BURST. The state register drives all muxing, so there is no combinational path from request to grant.
- Reset values:
  - state=IDLE; counters=0; proto_err=0.
  - grant_vga=0, grant_st=0.
  - vga_waitrequest=1, st_waitrequest=1.
  - sd_read=0, sd_write=0.
  - vga_readdatavalid=0, vga_readdata=0.
- IDLE:
  - Both waitrequests are 1; sd_read=sd_write=0.
  - If vga_read and not (st_write and starve==STARVE_MAX), go to RD_CMD.
  - Else if st_write, go to WR_BURST.
  - Arbitration latency: 1 cycle from request to forwarding.
- RD_CMD:
  - sd_* follows the VGA command (sd_write=0, byteenable all ones); vga_waitrequest=sd_waitrequest.
  - On sd_read and !sd_waitrequest: latch burstcount into beats_total, clear beats_rx, go to RD_DATA.
  - A latched burstcount of 0 is treated as 1 and sets proto_err.
- RD_DATA:
  - sd_read=0; vga_waitrequest=1.
  - vga_readdatavalid=sd_readdatavalid; vga_readdata=sd_readdata.
  - Each valid beat increments beats_rx. On the beat where beats_rx+1==beats_total, go to IDLE.
- WR_BURST:
  - sd_* follows the stream command (sd_read=0); st_waitrequest=sd_waitrequest.
  - The first accepted beat (st_write and !sd_waitrequest) latches burstcount (0 is treated as 1 and sets proto_err); each accepted beat increments beats_tx.
  - On the last accepted beat, go to IDLE. A burstcount=1 burst ends on its first beat.
  - Idle cycles with st_write=0 inside a burst are legal; the arbiter holds the grant.
- Outputs outside ownership:
  - Non-owner host sees waitrequest=1, readdata=0, readdatavalid=0.
  - stream has no read path.
- grant_vga=1 in RD_CMD and RD_DATA; grant_st=1 in WR_BURST.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) each cycle st_write=1 and state!=WR_BURST.
  - Clears on entry to WR_BURST.
  - Otherwise holds.
- Back-to-back: after a burst ends, the next grant is decided in IDLE (minimum 1 dead cycle). With both hosts pending, VGA wins unless the counter is saturated.
- sd_readdatavalid outside RD_DATA is dropped and sets proto_err.
- Reset mid-burst returns immediately to IDLE. SDRAM beats arriving afterwards are dropped and set proto_err; the SDRAM controller must be reset together with the arbiter.
- Width rules: counters are BCW bits; comparisons are at BCW width with no wrap (max 16 < 2^BCW).

Decomposition:
- Package avalon_arb_pkg holds:
  - arb_state_t enum {IDLE, RD_CMD, RD_DATA, WR_BURST};
  - default width constants AW_DEF, DW_DEF, BCW_DEF.
- Sub-module burst_beat_counter (load burstcount, count beats, flag last beat), instantiated once for the read path and once for the write path.

Test Plan:
- Single VGA read, burstcount=8, sd_waitrequest low, data latency 3 -> sd_read high 1 cycle after vga_read; exactly 8 vga_readdatavalid; grant_vga drops on the 8th beat; returns to IDLE.
- Stream write, burstcount=4, with sd_waitrequest high on beat 2 for 2 cycles -> 4 sd_write beats, data order preserved; st_waitrequest mirrors sd_waitrequest; ends after the 4th accepted beat.
- Both requesting in the same cycle in IDLE -> VGA granted first; stream granted in the IDLE decision right after the VGA burst completes.
- VGA reads back-to-back continuously, st_write held, STARVE_MAX=64 -> stream granted at the first arbitration point after 64 waiting cycles; counter cleared on grant.
- Reset asserted in RD_DATA after 3 of 8 beats, then 5 residual sd_readdatavalid -> all outputs at reset values; no vga_readdatavalid; proto_err=1.
- VGA read with burstcount=0 -> treated as 1 beat; proto_err=1; arbiter returns to IDLE after one beat.
